tx_buf_ctrl: RTL and testbench

TX_BUF_CTRL -- requirements
Module: tx_buf_ctrl

---
 rtl/tx_buf_ctrl.sv | 127 ++++++++++++
 tb/tb_tx_buf_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_buf_ctrl.sv
// tx_buf_ctrl: byte FIFO controller over an external dual-port BRAM,
// draining stored bytes to a UART transmitter via valid/ready.
module tx_buf_ctrl #(
    parameter int DEPTH = 200000,
    parameter int AW    = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [AW-1:0] count,
    output logic          overflow,
    output logic          ena,
    output logic          wea,
    output logic [AW-1:0] addra,
    output logic [7:0]    dia,
    output logic          enb,
    output logic [AW-1:0] addrb,
    input  logic [7:0]    dob,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND
    } state_t;

    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);
    // One extra bit so a buffer of exactly 2^AW bytes can still report full.
    localparam logic [AW:0]   FULLC = (AW+1)'(DEPTH);

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_overflow;
    logic [7:0]    r_tx_data;
    logic          w_full;
    logic          w_empty;
    logic          w_wr_acc;
    logic          w_rd_iss;

    function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + AW'(1);
    endfunction

    assign w_full   = (r_count == FULLC);
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = wr_en && !w_full && !rst;

    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = r_count[AW-1:0];
    assign overflow = r_overflow;
    assign ena      = w_wr_acc;
    assign wea      = w_wr_acc;
    assign addra    = r_wptr;
    assign dia      = wr_data;
    assign enb      = w_rd_iss;
    assign addrb    = r_rptr;
    assign tx_data  = r_tx_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_rd_iss = 1'b0;
        tx_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_empty && !rst) begin
                    w_rd_iss = 1'b1;
                    w_next   = LOAD;
                end
            end
            LOAD: w_next = SEND;
            SEND: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= f_inc(r_wptr);
            end
            if (w_rd_iss) begin
                r_rptr <= f_inc(r_rptr);
            end
            if (w_wr_acc && !w_rd_iss) begin
                r_count <= r_count + 1'b1;
            end else if (!w_wr_acc && w_rd_iss) begin
                r_count <= r_count - 1'b1;
            end
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
            if (r_state == LOAD) begin
                r_tx_data <= dob;
            end
        end
    end

endmodule

// File: tb/tb_tx_buf_ctrl.sv
// tb_tx_buf_ctrl: directed and random checks of tx_buf_ctrl against
// a queue-based occupancy/order model with a behavioural BRAM.
module tb_tx_buf_ctrl;

    localparam int DEPTH = 4;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [AW-1:0] count;
    logic          overflow;
    logic          ena;
    logic          wea;
    logic [AW-1:0] addra;
    logic [7:0]    dia;
    logic          enb;
    logic [AW-1:0] addrb;
    logic [7:0]    dob;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;

    tx_buf_ctrl #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .overflow(overflow),
        .ena     (ena),
        .wea     (wea),
        .addra   (addra),
        .dia     (dia),
        .enb     (enb),
        .addrb   (addrb),
        .dob     (dob),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [2**AW];
    always @(posedge clk) begin
        if (ena && wea) mem[addra] <= dia;
        if (enb) dob <= mem[addrb];
    end

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] q[$];
    int         occ     = 0;
    int         wcnt    = 0;
    int         rcnt    = 0;
    int         sent    = 0;
    logic       ovf_exp = 1'b0;
    logic       last_acc;
    logic       last_enb;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic       acc;
        logic       hs;
        logic [7:0] eb;
        #1;
        acc = 1'b0;
        hs  = 1'b0;
        if (rst) begin
            chk("rst_ena", 32'(ena), 0);
            chk("rst_wea", 32'(wea), 0);
            chk("rst_enb", 32'(enb), 0);
        end else begin
            acc = wr_en && (occ < DEPTH);
            chk("ena", 32'(ena), 32'(acc));
            chk("wea", 32'(wea), 32'(acc));
            if (acc) begin
                chk("addra", 32'(addra), 32'(wcnt % DEPTH));
                chk("dia", 32'(dia), 32'(wr_data));
            end
            if (enb) begin
                chk("addrb", 32'(addrb), 32'(rcnt % DEPTH));
                chk("rd_nonempty", 32'(occ > 0), 1);
            end
            hs = tx_valid && tx_ready;
            if (hs) begin
                if (q.size() == 0) begin
                    chk("tx_spurious", 32'(hs), 0);
                end else begin
                    eb = q.pop_front();
                    chk("tx_data", 32'(tx_data), 32'(eb));
                    sent++;
                end
            end
            if (wr_en && occ == DEPTH) ovf_exp = 1'b1;
        end
        last_acc = acc;
        last_enb = enb;
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            occ     = 0;
            wcnt    = 0;
            rcnt    = 0;
            ovf_exp = 1'b0;
        end else begin
            if (acc) begin
                q.push_back(wr_data);
                wcnt++;
                occ++;
            end
            if (last_enb) begin
                occ--;
                rcnt++;
            end
        end
        chk("count", 32'(count), 32'(occ));
        chk("empty", 32'(empty), 32'(occ == 0));
        chk("full", 32'(full), 32'(occ == DEPTH));
        chk("overflow", 32'(overflow), 32'(ovf_exp));
    endtask

    initial begin
        logic [7:0] held;
        rst      = 1'b1;
        wr_en    = 1'b1;
        wr_data  = 8'hAA;
        tx_ready = 1'b0;
        cycle();
        cycle();
        chk("rst_txv", 32'(tx_valid), 0);
        chk("rst_txd", 32'(tx_data), 0);
        rst   = 1'b0;
        wr_en = 1'b0;
        cycle();

        // single byte latency
        wr_en    = 1'b1;
        wr_data  = 8'h41;
        tx_ready = 1'b1;
        cycle();
        wr_en = 1'b0;
        chk("lat_enb", 32'(enb), 1);
        chk("lat_cnt1", 32'(count), 1);
        cycle();
        chk("lat_n2", 32'(tx_valid), 0);
        cycle();
        chk("lat_n3_v", 32'(tx_valid), 1);
        chk("lat_n3_d", 32'(tx_data), 32'h41);
        cycle();
        chk("lat_done", 32'(tx_valid), 0);
        chk("lat_empty", 32'(empty), 1);

        // back-pressure hold
        tx_ready = 1'b0;
        wr_en    = 1'b1;
        wr_data  = 8'hC3;
        cycle();
        wr_en = 1'b0;
        cycle();
        cycle();
        chk("hold_v0", 32'(tx_valid), 1);
        held = tx_data;
        for (int i = 0; i < 20; i++) begin
            cycle();
            chk("hold_v", 32'(tx_valid), 1);
            chk("hold_d", 32'(tx_data), 32'(held));
        end
        tx_ready = 1'b1;
        cycle();
        chk("hold_rel", 32'(tx_valid), 0);

        // fill to full, overflow, then reset in SEND
        rst = 1'b1;
        cycle();
        rst      = 1'b0;
        tx_ready = 1'b0;
        wr_en    = 1'b1;
        wr_data  = 8'h10;
        cycle();
        wr_en = 1'b0;
        cycle();
        cycle();
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h20 + i);
            cycle();
        end
        wr_en = 1'b0;
        chk("fill_cnt", 32'(count), 4);
        chk("fill_full", 32'(full), 1);
        chk("fill_ovf", 32'(overflow), 1);
        repeat (3) cycle();
        chk("ovf_sticky", 32'(overflow), 1);
        tx_ready = 1'b1;
        cycle();
        tx_ready = 1'b0;
        cycle();
        cycle();
        chk("mid_txv", 32'(tx_valid), 1);
        chk("mid_cnt", 32'(count), 3);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mid_rst_v", 32'(tx_valid), 0);
        chk("mid_rst_c", 32'(count), 0);
        chk("mid_rst_e", 32'(empty), 1);
        chk("mid_rst_o", 32'(overflow), 0);

        // simultaneous write and read issue at count 2
        wr_en   = 1'b1;
        wr_data = 8'h50;
        cycle();
        wr_en = 1'b0;
        cycle();
        cycle();
        wr_en   = 1'b1;
        wr_data = 8'h51;
        cycle();
        wr_data = 8'h52;
        cycle();
        wr_en    = 1'b0;
        tx_ready = 1'b1;
        cycle();
        tx_ready = 1'b0;
        chk("sim_pre", 32'(count), 2);
        wr_en   = 1'b1;
        wr_data = 8'h53;
        cycle();
        wr_en = 1'b0;
        chk("sim_enb", 32'(last_enb), 1);
        chk("sim_ena", 32'(last_acc), 1);
        chk("sim_cnt", 32'(count), 2);

        // stream 10 bytes across the pointer wrap
        rst = 1'b1;
        cycle();
        rst      = 1'b0;
        tx_ready = 1'b1;
        sent     = 0;
        for (int i = 0; i < 10; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(i);
            cycle();
            wr_en = 1'b0;
            cycle();
            cycle();
        end
        cycle();
        chk("stream_sent", 32'(sent), 10);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 99) == 0);
            wr_en    = $urandom_range(0, 1);
            wr_data  = 8'($urandom);
            tx_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        rst      = 1'b0;
        wr_en    = 1'b0;
        tx_ready = 1'b1;
        repeat (20) cycle();
        chk("drain", 32'(q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
